// File: rtl/turtle_cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : turtle_cpu_top (with instruction_memory, data_memory,
//            register_file, decoder)
// Brief    : Single-cycle 8-bit accumulator CPU with free-run/single-step
//            clocking.
// Revision : 1.0 - initial release
// ============================================================================

module instruction_memory (
    input  logic [9:0]  i_addr,
    output logic [15:0] o_data
);
    // Read-only program store; contents are loaded from outside the design.
    logic [15:0] mem [1024];

    assign o_data = mem[i_addr];
endmodule

module data_memory (
    input  logic       clk,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);
    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_addr];
endmodule

module register_file (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [2:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [2:0] i_raddr,
    output logic [7:0] o_rdata
);
    logic [7:0] mem [8];
    logic [7:0] gpr [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_gpr
        assign gpr[g] = mem[g];
    end

    assign o_rdata = gpr[i_raddr];
endmodule

module decoder (
    input  logic [15:0] i_instruction,
    output logic [3:0]  reg_mem_func,
    output logic [3:0]  alu_function,
    output logic        alu_output_enable,
    output logic        o_use_reg,
    output logic        o_is_reg_mem,
    output logic        o_jump_branch_select,
    output logic        o_unconditional_branch,
    output logic [2:0]  o_branch_condition,
    output logic        o_is_halt,
    output logic [2:0]  o_reg_sel,
    output logic [7:0]  o_imm8
);
    localparam logic [2:0] c_op_alu_imm     = 3'b000;
    localparam logic [2:0] c_op_alu_reg     = 3'b001;
    localparam logic [2:0] c_op_reg_memory  = 3'b010;
    localparam logic [2:0] c_op_jump_branch = 3'b011;
    localparam logic [2:0] c_op_halt        = 3'b111;

    logic [2:0] op;
    logic       w_unused_bit7;

    assign op            = i_instruction[2:0];
    assign reg_mem_func  = i_instruction[6:3];
    assign alu_function  = i_instruction[6:3];
    assign o_reg_sel     = i_instruction[10:8];
    assign o_imm8        = i_instruction[15:8];
    assign w_unused_bit7 = i_instruction[7];

    // Funcs 10..15 are undefined and must leave acc and flags untouched.
    assign alu_output_enable      = ((op == c_op_alu_imm) || (op == c_op_alu_reg))
                                    && (alu_function <= 4'd9);
    assign o_use_reg              = (op == c_op_alu_reg);
    assign o_is_reg_mem           = (op == c_op_reg_memory);
    assign o_jump_branch_select   = (op == c_op_jump_branch);
    assign o_unconditional_branch = i_instruction[3];
    assign o_branch_condition     = i_instruction[6:4];
    assign o_is_halt              = (op == c_op_halt);
endmodule

module turtle_cpu_top (
    input logic clk,
    input logic reset_btn,
    input logic manual_clk_sw,
    input logic pulse_clk_btn
);
    localparam logic [3:0] c_alu_add = 4'd0;
    localparam logic [3:0] c_alu_sub = 4'd1;
    localparam logic [3:0] c_alu_and = 4'd2;
    localparam logic [3:0] c_alu_or  = 4'd3;
    localparam logic [3:0] c_alu_xor = 4'd4;
    localparam logic [3:0] c_alu_inv = 4'd5;
    localparam logic [3:0] c_alu_inc = 4'd6;
    localparam logic [3:0] c_alu_dec = 4'd7;
    localparam logic [3:0] c_alu_shl = 4'd8;
    localparam logic [3:0] c_alu_shr = 4'd9;

    localparam logic [3:0] c_rm_load  = 4'd0;
    localparam logic [3:0] c_rm_store = 4'd1;
    localparam logic [3:0] c_rm_get   = 4'd2;
    localparam logic [3:0] c_rm_put   = 4'd3;
    localparam logic [3:0] c_rm_set   = 4'd4;

    logic        reset_n;
    logic        w_rst;
    logic [9:0]  pc;
    logic [15:0] instruction;
    logic [7:0]  acc_out;
    logic        r_flag_z;
    logic        r_flag_n;
    logic        r_flag_c;
    logic        r_halt;

    logic        r_btn_sync1;
    logic        r_btn_sync2;
    logic        r_btn_prev;
    logic        w_step;
    logic        w_commit;

    logic [3:0]  reg_mem_func;
    logic [3:0]  alu_function;
    logic        alu_output_enable;
    logic        w_use_reg;
    logic        w_is_reg_mem;
    logic        jump_branch_select;
    logic        unconditional_branch;
    logic [2:0]  branch_condition;
    logic        w_is_halt;
    logic [2:0]  w_reg_sel;
    logic [7:0]  w_imm8;

    logic [7:0]  w_gpr_rdata;
    logic [7:0]  w_dmem_rdata;
    logic [7:0]  w_alu_b;
    logic [8:0]  w_alu_full;
    logic        w_cond_met;
    logic        w_taken;

    logic [9:0]  w_pc_next;
    logic [7:0]  w_acc_next;
    logic        w_z_next;
    logic        w_n_next;
    logic        w_c_next;
    logic        w_halt_next;
    logic        w_gpr_we;
    logic        w_dmem_we;

    assign w_rst = ~reset_n;

    always_ff @(posedge clk) begin
        reset_n <= ~reset_btn;
    end

    // Button synchroniser and rising-edge detector for single-step mode.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_btn_sync1 <= 1'b0;
            r_btn_sync2 <= 1'b0;
            r_btn_prev  <= 1'b0;
        end else begin
            r_btn_sync1 <= pulse_clk_btn;
            r_btn_sync2 <= r_btn_sync1;
            r_btn_prev  <= r_btn_sync2;
        end
    end

    assign w_step   = reset_n & (manual_clk_sw ? (r_btn_sync2 & ~r_btn_prev) : 1'b1);
    assign w_commit = w_step & ~r_halt;

    instruction_memory instruction_memory_inst (
        .i_addr (pc),
        .o_data (instruction)
    );

    decoder decoder_inst (
        .i_instruction          (instruction),
        .reg_mem_func           (reg_mem_func),
        .alu_function           (alu_function),
        .alu_output_enable      (alu_output_enable),
        .o_use_reg              (w_use_reg),
        .o_is_reg_mem           (w_is_reg_mem),
        .o_jump_branch_select   (jump_branch_select),
        .o_unconditional_branch (unconditional_branch),
        .o_branch_condition     (branch_condition),
        .o_is_halt              (w_is_halt),
        .o_reg_sel              (w_reg_sel),
        .o_imm8                 (w_imm8)
    );

    register_file register_file_inst (
        .clk     (clk),
        .rst     (w_rst),
        .i_we    (w_commit & w_gpr_we),
        .i_waddr (w_reg_sel),
        .i_wdata (acc_out),
        .i_raddr (w_reg_sel),
        .o_rdata (w_gpr_rdata)
    );

    data_memory data_memory_inst (
        .clk     (clk),
        .i_we    (w_commit & w_dmem_we),
        .i_addr  (w_gpr_rdata),
        .i_wdata (acc_out),
        .o_rdata (w_dmem_rdata)
    );

    // Bit 8 of the 9-bit result carries the carry, borrow or shifted-out bit.
    always_comb begin
        w_alu_b    = w_use_reg ? w_gpr_rdata : w_imm8;
        w_alu_full = {1'b0, acc_out};
        case (alu_function)
            c_alu_add: w_alu_full = {1'b0, acc_out} + {1'b0, w_alu_b};
            c_alu_sub: w_alu_full = {1'b0, acc_out} - {1'b0, w_alu_b};
            c_alu_and: w_alu_full = {1'b0, acc_out & w_alu_b};
            c_alu_or:  w_alu_full = {1'b0, acc_out | w_alu_b};
            c_alu_xor: w_alu_full = {1'b0, acc_out ^ w_alu_b};
            c_alu_inv: w_alu_full = {1'b0, ~acc_out};
            c_alu_inc: w_alu_full = {1'b0, acc_out} + 9'd1;
            c_alu_dec: w_alu_full = {1'b0, acc_out} - 9'd1;
            c_alu_shl: w_alu_full = {acc_out, 1'b0};
            c_alu_shr: w_alu_full = {acc_out[0], 1'b0, acc_out[7:1]};
            default:   w_alu_full = {1'b0, acc_out};
        endcase
    end

    always_comb begin
        w_cond_met = 1'b0;
        case (branch_condition)
            3'd0:    w_cond_met = r_flag_z;
            3'd1:    w_cond_met = ~r_flag_z;
            3'd2:    w_cond_met = r_flag_n;
            3'd3:    w_cond_met = ~r_flag_n & ~r_flag_z;
            3'd4:    w_cond_met = r_flag_c;
            3'd5:    w_cond_met = ~r_flag_c;
            default: w_cond_met = 1'b0;
        endcase
    end

    assign w_taken = jump_branch_select & (unconditional_branch | w_cond_met);

    always_comb begin
        w_pc_next   = pc + 10'd1;
        w_acc_next  = acc_out;
        w_z_next    = r_flag_z;
        w_n_next    = r_flag_n;
        w_c_next    = r_flag_c;
        w_halt_next = r_halt;
        w_gpr_we    = 1'b0;
        w_dmem_we   = 1'b0;
        if (alu_output_enable) begin
            w_acc_next = w_alu_full[7:0];
            w_z_next   = (w_alu_full[7:0] == 8'h00);
            w_n_next   = w_alu_full[7];
            w_c_next   = w_alu_full[8];
        end else if (w_is_reg_mem) begin
            case (reg_mem_func)
                c_rm_load:  w_acc_next = w_dmem_rdata;
                c_rm_store: w_dmem_we  = 1'b1;
                c_rm_get:   w_acc_next = w_gpr_rdata;
                c_rm_put:   w_gpr_we   = 1'b1;
                c_rm_set:   w_acc_next = w_imm8;
                default:    w_acc_next = acc_out;
            endcase
        end else if (w_taken) begin
            // Offset is sign-extended to 10 bits so the target wraps mod 1024.
            w_pc_next = pc + {{2{w_imm8[7]}}, w_imm8};
        end else if (w_is_halt) begin
            w_pc_next   = pc;
            w_halt_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            pc       <= 10'd0;
            acc_out  <= 8'h00;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
            r_halt   <= 1'b0;
        end else if (w_commit) begin
            pc       <= w_pc_next;
            acc_out  <= w_acc_next;
            r_flag_z <= w_z_next;
            r_flag_n <= w_n_next;
            r_flag_c <= w_c_next;
            r_halt   <= w_halt_next;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_turtle_cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_turtle_cpu_top
// Brief    : Directed self-checking bench for the turtle single-cycle CPU.
// Revision : 1.0 - initial release
// ============================================================================

module tb_turtle_cpu_top;
    logic clk = 1'b0;
    logic reset_btn = 1'b1;
    logic manual_clk_sw = 1'b0;
    logic pulse_clk_btn = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    turtle_cpu_top dut (
        .clk           (clk),
        .reset_btn     (reset_btn),
        .manual_clk_sw (manual_clk_sw),
        .pulse_clk_btn (pulse_clk_btn)
    );

    always #5 clk = ~clk;

    task automatic fill_nop();
        for (int i = 0; i < 1024; i++) begin
            dut.instruction_memory_inst.mem[i] = 16'h0004;
        end
    endtask

    task automatic hold_reset();
        reset_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // After this returns pc=0 and every following edge is one step.
    task automatic release_reset();
        reset_btn = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        fill_nop();
        hold_reset();
        n_checks++;
        if (dut.reset_n !== 1'b0) begin
            n_errors++; $display("FAIL reset_n: got %b expected 0", dut.reset_n);
        end
        n_checks++;
        if (dut.pc !== 10'd0 || dut.acc_out !== 8'h00) begin
            n_errors++; $display("FAIL reset_pc_acc: got pc=%0d acc=%h expected pc=0 acc=00", dut.pc, dut.acc_out);
        end
        n_checks++;
        if ({dut.r_flag_z, dut.r_flag_n, dut.r_flag_c, dut.r_halt} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 0000",
                {dut.r_flag_z, dut.r_flag_n, dut.r_flag_c, dut.r_halt});
        end
    endtask

    task automatic test_free_run();
        hold_reset();
        dut.instruction_memory_inst.mem[0] = 16'h0522;
        dut.instruction_memory_inst.mem[1] = 16'h011A;
        dut.instruction_memory_inst.mem[2] = 16'h0300;
        dut.instruction_memory_inst.mem[3] = 16'h0007;
        release_reset();
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (dut.register_file_inst.gpr[1] !== 8'h05) begin
            n_errors++; $display("FAIL free_run_gpr1: got %h expected 05", dut.register_file_inst.gpr[1]);
        end
        n_checks++;
        if (dut.acc_out !== 8'h08) begin
            n_errors++; $display("FAIL free_run_acc: got %h expected 08", dut.acc_out);
        end
        n_checks++;
        if (dut.pc !== 10'd3 || dut.r_halt !== 1'b1) begin
            n_errors++; $display("FAIL free_run_halt: got pc=%0d halt=%b expected pc=3 halt=1", dut.pc, dut.r_halt);
        end
    endtask

    task automatic test_overflow();
        hold_reset();
        fill_nop();
        dut.instruction_memory_inst.mem[0] = 16'hFF22;
        dut.instruction_memory_inst.mem[1] = 16'h0030;
        dut.instruction_memory_inst.mem[2] = 16'hFE03;
        release_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut.acc_out !== 8'h00 || dut.pc !== 10'd2) begin
            n_errors++; $display("FAIL overflow_acc: got acc=%h pc=%0d expected acc=00 pc=2", dut.acc_out, dut.pc);
        end
        n_checks++;
        if ({dut.r_flag_z, dut.r_flag_n, dut.r_flag_c} !== 3'b101) begin
            n_errors++; $display("FAIL overflow_flags: got znc=%b expected 101",
                {dut.r_flag_z, dut.r_flag_n, dut.r_flag_c});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.pc !== 10'd0) begin
            n_errors++; $display("FAIL overflow_branch: got pc=%0d expected 0", dut.pc);
        end
    endtask

    task automatic test_alu();
        logic [15:0] prog [16];
        logic [7:0]  exp_acc [16];
        logic [2:0]  exp_znc [16];
        prog    = '{16'h8122, 16'h0040, 16'h0048, 16'h0038, 16'h0038, 16'h0F20, 16'h0518, 16'h3C10,
                    16'h0028, 16'hCC08, 16'h1250, 16'h031A, 16'h0122, 16'h0301, 16'h0312, 16'h0007};
        exp_acc = '{8'h81, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hF0, 8'hF5, 8'h34,
                    8'hCB, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFF};
        exp_znc = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b011, 3'b010, 3'b010, 3'b000,
                    3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b101, 3'b101, 3'b101};
        hold_reset();
        fill_nop();
        for (int i = 0; i < 16; i++) begin
            dut.instruction_memory_inst.mem[i] = prog[i];
        end
        release_reset();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (dut.acc_out !== exp_acc[i] || {dut.r_flag_z, dut.r_flag_n, dut.r_flag_c} !== exp_znc[i]) begin
                n_errors++; $display("FAIL alu_step%0d: got acc=%h znc=%b expected acc=%h znc=%b", i,
                    dut.acc_out, {dut.r_flag_z, dut.r_flag_n, dut.r_flag_c}, exp_acc[i], exp_znc[i]);
            end
        end
        n_checks++;
        if (dut.pc !== 10'd15 || dut.register_file_inst.gpr[3] !== 8'hFF) begin
            n_errors++; $display("FAIL alu_end: got pc=%0d r3=%h expected pc=15 r3=ff", dut.pc,
                dut.register_file_inst.gpr[3]);
        end
    endtask

    task automatic test_memory();
        hold_reset();
        fill_nop();
        dut.instruction_memory_inst.mem[0] = 16'h1022;
        dut.instruction_memory_inst.mem[1] = 16'h021A;
        dut.instruction_memory_inst.mem[2] = 16'hAB22;
        dut.instruction_memory_inst.mem[3] = 16'h020A;
        dut.instruction_memory_inst.mem[4] = 16'h0022;
        dut.instruction_memory_inst.mem[5] = 16'h0202;
        dut.instruction_memory_inst.mem[6] = 16'h0007;
        release_reset();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (dut.acc_out !== 8'h00 || dut.data_memory_inst.mem[8'h10] !== 8'hAB) begin
            n_errors++; $display("FAIL memory_store: got acc=%h dmem=%h expected acc=00 dmem=ab",
                dut.acc_out, dut.data_memory_inst.mem[8'h10]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dut.acc_out !== 8'hAB || dut.register_file_inst.gpr[2] !== 8'h10) begin
            n_errors++; $display("FAIL memory_load: got acc=%h r2=%h expected acc=ab r2=10",
                dut.acc_out, dut.register_file_inst.gpr[2]);
        end
    endtask

    task automatic test_branch();
        logic [9:0] exp_pc [9];
        exp_pc = '{10'd1, 10'd2, 10'd3, 10'd6, 10'd8, 10'd9, 10'd25, 10'd26, 10'd26};
        hold_reset();
        fill_nop();
        dut.instruction_memory_inst.mem[0]  = 16'h8022;
        dut.instruction_memory_inst.mem[1]  = 16'h0018;
        dut.instruction_memory_inst.mem[2]  = 16'h0503;
        dut.instruction_memory_inst.mem[3]  = 16'h0323;
        dut.instruction_memory_inst.mem[6]  = 16'h0253;
        dut.instruction_memory_inst.mem[8]  = 16'h0463;
        dut.instruction_memory_inst.mem[9]  = 16'h100B;
        dut.instruction_memory_inst.mem[25] = 16'h0233;
        dut.instruction_memory_inst.mem[26] = 16'h0007;
        release_reset();
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (dut.pc !== exp_pc[i]) begin
                n_errors++; $display("FAIL branch_step%0d: got pc=%0d expected %0d", i, dut.pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_single_step();
        hold_reset();
        fill_nop();
        manual_clk_sw = 1'b1;
        release_reset();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (dut.pc !== 10'd0) begin
            n_errors++; $display("FAIL single_step_idle: got pc=%0d expected 0", dut.pc);
        end
        for (int k = 1; k <= 3; k++) begin
            pulse_clk_btn = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            pulse_clk_btn = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            n_checks++;
            if (dut.pc !== 10'(k)) begin
                n_errors++; $display("FAIL single_step_pulse%0d: got pc=%0d expected %0d", k, dut.pc, k);
            end
        end
        hold_reset();
        manual_clk_sw = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic any_gpr;
        hold_reset();
        fill_nop();
        dut.instruction_memory_inst.mem[0] = 16'h1022;
        dut.instruction_memory_inst.mem[1] = 16'h021A;
        dut.instruction_memory_inst.mem[2] = 16'hAB22;
        dut.instruction_memory_inst.mem[3] = 16'h020A;
        dut.instruction_memory_inst.mem[4] = 16'h0030;
        dut.instruction_memory_inst.mem[5] = 16'hFF0B;
        release_reset();
        repeat (20) @(posedge clk);
        #1;
        reset_btn = 1'b1;
        @(posedge clk);
        #1;
        reset_btn = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.pc !== 10'd0 || dut.acc_out !== 8'h00) begin
            n_errors++; $display("FAIL reset_mid_pc_acc: got pc=%0d acc=%h expected pc=0 acc=00", dut.pc, dut.acc_out);
        end
        any_gpr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            any_gpr = any_gpr | (|dut.register_file_inst.gpr[i]);
        end
        n_checks++;
        if (any_gpr !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid_gpr: got nonzero=%b expected 0", any_gpr);
        end
        n_checks++;
        if (dut.data_memory_inst.mem[8'h10] !== 8'hAB) begin
            n_errors++; $display("FAIL reset_mid_dmem: got %h expected ab", dut.data_memory_inst.mem[8'h10]);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.pc !== 10'd1 || dut.acc_out !== 8'h10) begin
            n_errors++; $display("FAIL reset_mid_resume: got pc=%0d acc=%h expected pc=1 acc=10", dut.pc, dut.acc_out);
        end
    endtask

    task automatic test_wrap();
        hold_reset();
        fill_nop();
        release_reset();
        repeat (1025) @(posedge clk);
        #1;
        n_checks++;
        if (dut.pc !== 10'd1) begin
            n_errors++; $display("FAIL wrap_nop: got pc=%0d expected 1", dut.pc);
        end
        hold_reset();
        dut.instruction_memory_inst.mem[0] = 16'hFF0B;
        release_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.pc !== 10'd1023) begin
            n_errors++; $display("FAIL wrap_branch_back: got pc=%0d expected 1023", dut.pc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.pc !== 10'd0) begin
            n_errors++; $display("FAIL wrap_inc: got pc=%0d expected 0", dut.pc);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_overflow();
        test_alu();
        test_memory();
        test_branch();
        test_single_step();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/turtle_cpu_top.md
TURTLE_CPU_TOP -- requirements
Module: turtle_cpu_top

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_btn  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: manual_clk_sw  input  1  1 = single-step mode, 0 = free-run mode.
REQ-004 SHALL have port: pulse_clk_btn  input  1  step button, used only in single-step mode.
REQ-005 SHALL have no outputs; state is observed hierarchically through the names in REQ-006.
REQ-006 SHALL expose these internal names:
- clk, reset_n (= registered ~reset_btn), pc[9:0], instruction[15:0], acc_out[7:0], jump_branch_select, unconditional_branch, branch_condition.
- Instances instruction_memory_inst.mem (1024x16), data_memory_inst.mem (256x8), register_file_inst.mem (8x8), register_file_inst.gpr (same contents as mem), decoder_inst with op, reg_mem_func, alu_function, alu_output_enable.

Function
REQ-007 SHALL be a single-cycle CPU with one instruction retired per step.
- Free-run mode: step every clk cycle.
- Single-step mode: step one cycle after each rising edge of pulse_clk_btn, using a 2-FF synchronizer plus edge detect; holding the button gives one step.
REQ-008 SHALL use the following memory timing:
- Instruction memory: asynchronous read at pc; no write port.
- Data memory: asynchronous read; synchronous write on step.
- Register file: 8x8, asynchronous read, synchronous write.
REQ-009 SHALL use instruction fields: op=instr[2:0], func=instr[6:3], reg=instr[10:8], imm8=instr[15:8].
REQ-010 SHALL implement OPCODE_ALU_IMM (000) as acc <= ALU(acc, imm8, func).
REQ-011 SHALL implement OPCODE_ALU_REG (001) as acc <= ALU(acc, gpr[reg], func).
REQ-012 SHALL implement ALU functions ADD0 SUB1 AND2 OR3 XOR4 INV5 INC6 DEC7 SHL8 SHR9, with these rules:
- All arithmetic is 8-bit modulo 256.
- Flags Z (result==0), N (result[7]) and C (carry-out / borrow / bit shifted out) update only on ALU opcodes.
- Undefined func: acc and flags unchanged.
REQ-013 SHALL implement OPCODE_REG_MEMORY (010) per func:
- LOAD0: acc <= dmem[gpr[reg]].
- STORE1: dmem[gpr[reg]] <= acc.
- GET2: acc <= gpr[reg].
- PUT3: gpr[reg] <= acc.
- SET4: acc <= imm8.
- Other func: no-op.
REQ-014 SHALL implement OPCODE_JUMP_BRANCH (011) as follows:
- jump_branch_select=1; unconditional_branch=instr[3].
- branch_condition=instr[6:4]: ZERO0 NOT_ZERO1 NEGATIVE2 POSITIVE3 (!N&&!Z) CARRY_SET4 CARRY_CLEAR5.
- If taken, pc <= pc + sign-extended imm8; otherwise pc <= pc+1.
- Conditions 6-7 are never taken.
REQ-015 SHALL implement OPCODE_HALT (111) as pc held and no state change until reset; opcodes 100-110 SHALL be NOPs.
REQ-016 SHALL compute pc modulo 1024; pc+1 from 1023 wraps to 0, and branch targets wrap likewise.
REQ-017 SHALL ignore the step pulse while reset_n==0.

Reset
REQ-018 SHALL update reset_n <= ~reset_btn on each clk edge.
REQ-019 SHALL, while reset_n==0, set on each clk edge: pc=0, acc=0, Z=N=C=0, all gpr=0, halt cleared, synchronizer and edge-detect flops=0.
REQ-020 SHALL NOT reset instruction or data memory contents.
REQ-021 SHALL apply reset asserted mid-program on the next edge, overriding any step in that cycle.

Verification
REQ-022 Free-run test: program SET 5; PUT r1; ADD_IMM 3; HALT -> gpr[1]=0x05, acc=0x08, pc stays at 3.
REQ-023 Overflow test: SET 0xFF; INC_IMM -> acc=0x00, Z=1, C=1; next BRANCH ZERO with offset -2 is taken.
REQ-024 Memory test: SET 0x10; PUT r2; SET 0xAB; STORE r2; SET 0; LOAD r2 -> dmem[0x10]=0xAB, acc=0xAB.
REQ-025 Single-step test: manual_clk_sw=1, 3 button pulses each held 10 cycles -> pc advances exactly 0 to 3.
REQ-026 Reset test: reset_btn=1 for 1 cycle mid-run -> next edge pc=0, acc=0, gpr all 0, dmem unchanged.
REQ-027 Wrap test: NOP-filled memory run 1025 steps -> pc=1.
